qtree_launch_sequencer: RTL and testbench
=========================================

Name: qtree_launch_sequencer

Overview:
- Sequences one kernel invocation of a generated dataflow DUT that consumes heap-resident QTree arguments.
- Waits until every argument stream deserializer has finished loading its tree and latched a root pointer, then issues the Go token and the argument root-pointer tokens exactly once each.
- Waits for the result token, holds it for the host and reports cycle count. Replaces the ad-hoc per-argument done flags in the wrapper.

Parameters:
- NUM_ARGS, 3, number of pointer arguments (1..8)
- PTR_W, 9, argument token width; bit 0 is the token valid bit, bits [PTR_W-1:1] are the pointer
- RES_W, 32, result token width; bit 0 is the valid bit
- CNT_W, 32, cycle counter width

Ports:
- clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- start  in  1  host request to launch (level; sampled in IDLE)
- arg_loaded  in  NUM_ARGS  per-argument "stream fully deserialized" flag from loaders
- arg_ptr  in  NUM_ARGS*PTR_W  root pointer tokens from loaders; arg i at [i*PTR_W +: PTR_W]
- go_d  out  1  Go token to DUT
- go_r  in  1  DUT ready for Go
- arg_d  out  NUM_ARGS*PTR_W  argument tokens to DUT
- arg_r  in  NUM_ARGS  DUT ready per argument
- res_d  in  RES_W  result token from DUT
- res_r  out  1  ready to DUT result channel
- result_data  out  RES_W  captured result
- done  out  1  result valid to host
- done_ack  in  1  host consumed result
- busy  out  1  high in any state other than IDLE
- cycles  out  CNT_W  cycles from FIRE entry to result capture

Behaviour:
- Token transfer on a channel occurs in a cycle where token bit 0 == 1 and its ready == 1. For go this is go_d == 1 && go_r == 1.
- Reset (async assert, sync deassert): state=IDLE; go_d=0; arg_d=0; res_r=0; result_data=0; done=0; busy=0; cycles=0; internal sent flags cleared.
- FSM states:
  - IDLE: busy=0. If start==1, go to WAIT_LOAD next cycle.
  - WAIT_LOAD: if arg_loaded is all ones, latch every arg_ptr with bit 0 forced to 1 into arg_d, set go_d=1, clear cycles, go to FIRE.
  - FIRE: each of go and arg[i] has its own sent flag. On its transfer cycle the token's bit 0 drops to 0 the next cycle and stays 0; no channel is ever re-sent. Channels complete independently and in any order. cycles increments every cycle. When all NUM_ARGS+1 flags are set, go to RUN with res_r=1.
  - RUN: cycles increments. When res_d[0]==1 (res_r is 1), result_data<=res_d, done<=1, res_r<=0, cycles freezes; go to DONE.
  - DONE: hold done=1 and result_data. If done_ack==1, next cycle done=0 and state=IDLE; result_data is retained.
- Latency: FIRE is entered 1 cycle after all arg_loaded go high. With all readies high, tokens are in flight for exactly 1 cycle and RUN is entered 1 cycle later. done rises 1 cycle after the result transfer.
- res_r is 0 in every state except RUN, so a result token arriving early is back-pressured and not lost.
- arg_loaded deasserting after WAIT_LOAD is ignored (pointers already latched).
- cycles saturates at all ones; it does not wrap.
- start held high through DONE does not skip DONE. A new launch needs IDLE to sample start again, so a continuous start relaunches right after the ack.
- If done_ack arrives in the same cycle done first rises, it is honored in the next cycle. done is high for at least 1 cycle.
- Reset asserted mid-FIRE/RUN aborts immediately; outputs return to reset values. The DUT must be reset by the same aresetn.
- NUM_ARGS==1 is legal; arg_r width 1.

Test Plan:
- Basic launch, NUM_ARGS=3, all readies high: start=1, arg_loaded=3'b111 with ptrs 0x10,0x22,0x05 -> go_d and each arg_d bit0 high for exactly 1 cycle with pointers 0x10,0x22,0x05. res_d=0x0000_002B at RUN+4 -> result_data=0x2B, done=1, cycles=6.
- Staggered ready: arg_r[1] held low 5 cycles, go_r low 2 cycles -> each token stays stable until its own transfer. No channel transfers twice. RUN entered the cycle after the last transfer.
- Staggered load: arg_loaded rises 3'b001, then 3'b011, then 3'b111 at cycles 2/7/12 -> go_d stays 0 until cycle 13. Pointers latched at cycle 12 values.
- Early result: res_d[0]=1 during FIRE -> res_r=0, no capture. Capture occurs on the first RUN cycle.
- done handshake: done_ack held 0 for 10 cycles -> done and result_data stable. done_ack=1 -> done=0 next cycle, busy=0. start held 1 -> WAIT_LOAD entered the following cycle.
- Reset mid-RUN: aresetn=0 asynchronously -> go_d=0, arg_d=0, res_r=0, done=0, busy=0 without waiting for clk. After release, start=1 relaunches cleanly.

Source files
------------

// File: rtl/qtree_launch_sequencer.sv
// -----------------------------------------------------------------------------
// qtree_launch_sequencer
//
// Sequences one kernel invocation of a generated dataflow DUT whose arguments
// are heap-resident QTrees. Waits for every argument loader to finish and latch
// its root pointer, then issues the Go token and each argument root-pointer
// token exactly once. Afterwards it waits for the result token, holds it for
// the host and reports how many cycles passed between FIRE entry and capture.
//
// Ports
//   clk, aresetn   clock and asynchronous active-low reset
//   start          host launch request (level, sampled in IDLE)
//   arg_loaded     per-argument "tree fully deserialized" flags
//   arg_ptr        root pointer tokens from loaders, arg i at [i*PTR_W +: PTR_W]
//   go_d / go_r    Go token to DUT and its ready
//   arg_d / arg_r  argument tokens to DUT and per-argument readies
//   res_d / res_r  result token from DUT and its ready
//   result_data    captured result token
//   done/done_ack  result valid to host and host acknowledge
//   busy           high whenever not IDLE
//   cycles         saturating cycle count, FIRE entry to result capture
//
// Token convention: bit 0 is the valid bit; a transfer happens when the valid
// bit and the channel ready are both high in the same cycle.
// -----------------------------------------------------------------------------
module qtree_launch_sequencer #(
  parameter int unsigned NUM_ARGS = 3,
  parameter int unsigned PTR_W    = 9,
  parameter int unsigned RES_W    = 32,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic                      start,
  input  logic [NUM_ARGS-1:0]       arg_loaded,
  input  logic [NUM_ARGS*PTR_W-1:0] arg_ptr,
  output logic                      go_d,
  input  logic                      go_r,
  output logic [NUM_ARGS*PTR_W-1:0] arg_d,
  input  logic [NUM_ARGS-1:0]       arg_r,
  input  logic [RES_W-1:0]          res_d,
  output logic                      res_r,
  output logic [RES_W-1:0]          result_data,
  output logic                      done,
  input  logic                      done_ack,
  output logic                      busy,
  output logic [CNT_W-1:0]          cycles
);

  localparam int unsigned ARGS_W = NUM_ARGS * PTR_W;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOAD = 3'd1,
    S_FIRE      = 3'd2,
    S_RUN       = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  state_e              state_q,    state_d;
  logic                go_tok_q,   go_tok_d;
  logic [ARGS_W-1:0]   arg_tok_q,  arg_tok_d;
  logic                go_sent_q,  go_sent_d;
  logic [NUM_ARGS-1:0] arg_sent_q, arg_sent_d;
  logic                res_rdy_q,  res_rdy_d;
  logic [RES_W-1:0]    result_q,   result_d;
  logic                done_q,     done_d;
  logic                busy_q,     busy_d;
  logic [CNT_W-1:0]    cycles_q,   cycles_d;

  logic [CNT_W-1:0]    cycles_inc_c;

  // Saturating increment: the counter sticks at all ones instead of wrapping.
  always_comb begin
    cycles_inc_c = cycles_q;
    if (cycles_q != {CNT_W{1'b1}}) begin
      cycles_inc_c = cycles_q + CNT_W'(1);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    go_tok_d   = go_tok_q;
    arg_tok_d  = arg_tok_q;
    go_sent_d  = go_sent_q;
    arg_sent_d = arg_sent_q;
    res_rdy_d  = res_rdy_q;
    result_d   = result_q;
    done_d     = done_q;
    cycles_d   = cycles_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT_LOAD;
        end
      end

      S_WAIT_LOAD: begin
        // Latch all root pointers at once; the valid bit is forced because the
        // pointer itself is what matters once the loader reports done.
        if (&arg_loaded) begin
          for (int unsigned i = 0; i < NUM_ARGS; i++) begin
            arg_tok_d[i*PTR_W +: PTR_W] = arg_ptr[i*PTR_W +: PTR_W] | PTR_W'(1);
          end
          go_tok_d   = 1'b1;
          go_sent_d  = 1'b0;
          arg_sent_d = '0;
          cycles_d   = '0;
          state_d    = S_FIRE;
        end
      end

      S_FIRE: begin
        cycles_d = cycles_inc_c;
        // Each channel completes on its own; once sent the valid bit stays low.
        if (go_tok_q && go_r) begin
          go_tok_d  = 1'b0;
          go_sent_d = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_ARGS; i++) begin
          if (arg_tok_q[i*PTR_W] && arg_r[i]) begin
            arg_tok_d[i*PTR_W] = 1'b0;
            arg_sent_d[i]      = 1'b1;
          end
        end
        // Leave as soon as the last transfer happens, not a cycle later.
        if (go_sent_d && (&arg_sent_d)) begin
          res_rdy_d = 1'b1;
          state_d   = S_RUN;
        end
      end

      S_RUN: begin
        // The capture cycle itself is still counted; the count freezes after.
        cycles_d = cycles_inc_c;
        if (res_rdy_q && res_d[0]) begin
          result_d  = res_d;
          done_d    = 1'b1;
          res_rdy_d = 1'b0;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        if (done_ack) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      go_tok_q   <= 1'b0;
      arg_tok_q  <= '0;
      go_sent_q  <= 1'b0;
      arg_sent_q <= '0;
      res_rdy_q  <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      cycles_q   <= '0;
    end else begin
      state_q    <= state_d;
      go_tok_q   <= go_tok_d;
      arg_tok_q  <= arg_tok_d;
      go_sent_q  <= go_sent_d;
      arg_sent_q <= arg_sent_d;
      res_rdy_q  <= res_rdy_d;
      result_q   <= result_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      cycles_q   <= cycles_d;
    end
  end

  assign go_d        = go_tok_q;
  assign arg_d       = arg_tok_q;
  assign res_r       = res_rdy_q;
  assign result_data = result_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign cycles      = cycles_q;

endmodule

// File: tb/tb_qtree_launch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_qtree_launch_sequencer
//
// Directed bench for qtree_launch_sequencer (NUM_ARGS=3, PTR_W=9). Inputs are
// driven and outputs sampled at the falling clock edge; the DUT acts on the
// rising edge. A monitor counts token transfers per channel so each scenario
// can confirm every channel fired exactly once.
// -----------------------------------------------------------------------------
module tb_qtree_launch_sequencer;

  localparam int NA = 3;
  localparam int PW = 9;
  localparam int RW = 32;
  localparam int CW = 32;

  logic             clk = 1'b0;
  logic             aresetn;
  logic             start;
  logic [NA-1:0]    arg_loaded;
  logic [NA*PW-1:0] arg_ptr;
  logic             go_d;
  logic             go_r;
  logic [NA*PW-1:0] arg_d;
  logic [NA-1:0]    arg_r;
  logic [RW-1:0]    res_d;
  logic             res_r;
  logic [RW-1:0]    result_data;
  logic             done;
  logic             done_ack;
  logic             busy;
  logic [CW-1:0]    cycles;

  int checks   = 0;
  int failures = 0;
  int go_x     = 0;
  int arg_x [NA];

  qtree_launch_sequencer #(
    .NUM_ARGS(NA), .PTR_W(PW), .RES_W(RW), .CNT_W(CW)
  ) dut (
    .clk(clk), .aresetn(aresetn), .start(start), .arg_loaded(arg_loaded),
    .arg_ptr(arg_ptr), .go_d(go_d), .go_r(go_r), .arg_d(arg_d), .arg_r(arg_r),
    .res_d(res_d), .res_r(res_r), .result_data(result_data), .done(done),
    .done_ack(done_ack), .busy(busy), .cycles(cycles)
  );

  always #5 clk = ~clk;

  // Transfer monitor: counts valid&&ready at each active edge.
  always @(posedge clk) begin
    if (aresetn) begin
      if (go_d && go_r) go_x++;
      for (int i = 0; i < NA; i++) begin
        if (arg_d[i*PW] && arg_r[i]) arg_x[i]++;
      end
    end
  end

  function automatic logic [PW-1:0] tk(input logic [7:0] p, input logic v);
    return {p, v};
  endfunction

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    aresetn = 1'b0; start = 1'b1; arg_loaded = '1; arg_ptr = '1;
    go_r = 1'b1; arg_r = '1; res_d = '1; done_ack = 1'b0;
    mid(); mid();
    checks++; if (go_d !== 1'b0 || arg_d !== '0 || res_r !== 1'b0) begin
      failures++; $display("FAIL reset_tokens go_d=%0b arg_d=%h res_r=%0b exp 0/0/0", go_d, arg_d, res_r); end
    checks++; if (done !== 1'b0 || busy !== 1'b0 || result_data !== '0 || cycles !== '0) begin
      failures++; $display("FAIL reset_status done=%0b busy=%0b result=%h cycles=%0d exp all 0", done, busy, result_data, cycles); end
    start = 1'b0; arg_loaded = '0; arg_ptr = '0; res_d = '0;
    aresetn = 1'b1;
    mid();
    checks++; if (busy !== 1'b0 || go_d !== 1'b0) begin
      failures++; $display("FAIL reset_release busy=%0b go_d=%0b exp 0/0", busy, go_d); end
  endtask

  task automatic test_basic();
    int g0; int a0 [NA];
    g0 = go_x; a0 = arg_x;
    go_r = 1'b1; arg_r = '1; res_d = '0; arg_loaded = '1; start = 1'b1;
    arg_ptr = {tk(8'h05, 1'b1), tk(8'h22, 1'b0), tk(8'h10, 1'b1)};
    mid();                                   // WAIT_LOAD
    checks++; if (busy !== 1'b1 || go_d !== 1'b0) begin
      failures++; $display("FAIL basic_wait busy=%0b go_d=%0b exp 1/0", busy, go_d); end
    start = 1'b0;
    mid();                                   // FIRE
    checks++; if (go_d !== 1'b1 || res_r !== 1'b0 || cycles !== 0) begin
      failures++; $display("FAIL basic_fire go_d=%0b res_r=%0b cycles=%0d exp 1/0/0", go_d, res_r, cycles); end
    checks++; if (arg_d !== {tk(8'h05, 1'b1), tk(8'h22, 1'b1), tk(8'h10, 1'b1)}) begin
      failures++; $display("FAIL basic_fire_args arg_d=%h exp %h", arg_d, {tk(8'h05, 1'b1), tk(8'h22, 1'b1), tk(8'h10, 1'b1)}); end
    mid();                                   // RUN
    checks++; if (go_d !== 1'b0 || res_r !== 1'b1 || cycles !== 1) begin
      failures++; $display("FAIL basic_run go_d=%0b res_r=%0b cycles=%0d exp 0/1/1", go_d, res_r, cycles); end
    checks++; if (arg_d !== {tk(8'h05, 1'b0), tk(8'h22, 1'b0), tk(8'h10, 1'b0)}) begin
      failures++; $display("FAIL basic_run_args arg_d=%h exp %h", arg_d, {tk(8'h05, 1'b0), tk(8'h22, 1'b0), tk(8'h10, 1'b0)}); end
    mid(); mid(); mid();                     // RUN+3
    checks++; if (done !== 1'b0 || res_r !== 1'b1 || cycles !== 4) begin
      failures++; $display("FAIL basic_wait_res done=%0b res_r=%0b cycles=%0d exp 0/1/4", done, res_r, cycles); end
    mid();                                   // RUN+4
    res_d = 32'h0000_002B;
    mid();
    checks++; if (done !== 1'b1 || result_data !== 32'h2B || cycles !== 6 || res_r !== 1'b0) begin
      failures++; $display("FAIL basic_done done=%0b result=%h cycles=%0d res_r=%0b exp 1/2b/6/0", done, result_data, cycles, res_r); end
    res_d = '0; done_ack = 1'b1;
    mid();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || result_data !== 32'h2B) begin
      failures++; $display("FAIL basic_ack done=%0b busy=%0b result=%h exp 0/0/2b", done, busy, result_data); end
    done_ack = 1'b0;
    checks++; if (go_x - g0 !== 1) begin
      failures++; $display("FAIL basic_go_xfers got=%0d exp 1", go_x - g0); end
    for (int i = 0; i < NA; i++) begin
      checks++; if (arg_x[i] - a0[i] !== 1) begin
        failures++; $display("FAIL basic_arg_xfers arg%0d got=%0d exp 1", i, arg_x[i] - a0[i]); end
    end
  endtask

  task automatic test_staggered_ready();
    int g0; int a0 [NA];
    g0 = go_x; a0 = arg_x;
    go_r = 1'b0; arg_r = 3'b101; arg_loaded = '1; start = 1'b1; res_d = '0;
    arg_ptr = {tk(8'h53, 1'b1), tk(8'h42, 1'b1), tk(8'h31, 1'b1)};
    mid(); start = 1'b0;                     // WAIT_LOAD
    mid();                                   // T
    checks++; if (go_d !== 1'b1 || arg_d !== {tk(8'h53, 1'b1), tk(8'h42, 1'b1), tk(8'h31, 1'b1)}) begin
      failures++; $display("FAIL stag_fire go_d=%0b arg_d=%h", go_d, arg_d); end
    mid();                                   // T+1
    checks++; if (go_d !== 1'b1 || arg_d[0] !== 1'b0 || arg_d[2*PW] !== 1'b0 || arg_d[PW] !== 1'b1 || res_r !== 1'b0) begin
      failures++; $display("FAIL stag_t1 go_d=%0b arg_d=%h res_r=%0b", go_d, arg_d, res_r); end
    mid(); go_r = 1'b1;                      // T+2
    mid();                                   // T+3
    checks++; if (go_d !== 1'b0 || arg_d[PW +: PW] !== tk(8'h42, 1'b1) || res_r !== 1'b0) begin
      failures++; $display("FAIL stag_t3 go_d=%0b arg1=%h res_r=%0b exp 0/%h/0", go_d, arg_d[PW +: PW], res_r, tk(8'h42, 1'b1)); end
    mid(); mid();                            // T+5
    checks++; if (res_r !== 1'b0 || arg_d[PW +: PW] !== tk(8'h42, 1'b1) || busy !== 1'b1) begin
      failures++; $display("FAIL stag_t5 res_r=%0b arg1=%h busy=%0b", res_r, arg_d[PW +: PW], busy); end
    arg_r = '1;
    mid();                                   // T+6 : RUN
    checks++; if (res_r !== 1'b1 || arg_d !== {tk(8'h53, 1'b0), tk(8'h42, 1'b0), tk(8'h31, 1'b0)}) begin
      failures++; $display("FAIL stag_run res_r=%0b arg_d=%h", res_r, arg_d); end
    res_d = 32'h0000_1001;
    mid();
    checks++; if (done !== 1'b1 || result_data !== 32'h1001 || cycles !== 7) begin
      failures++; $display("FAIL stag_done done=%0b result=%h cycles=%0d exp 1/1001/7", done, result_data, cycles); end
    res_d = '0; done_ack = 1'b1;
    mid(); done_ack = 1'b0;
    checks++; if (go_x - g0 !== 1) begin
      failures++; $display("FAIL stag_go_xfers got=%0d exp 1", go_x - g0); end
    for (int i = 0; i < NA; i++) begin
      checks++; if (arg_x[i] - a0[i] !== 1) begin
        failures++; $display("FAIL stag_arg_xfers arg%0d got=%0d exp 1", i, arg_x[i] - a0[i]); end
    end
  endtask

  task automatic test_staggered_load();
    go_r = 1'b1; arg_r = '1; res_d = '0; arg_loaded = '0; start = 1'b1;
    arg_ptr = {tk(8'hAA, 1'b1), tk(8'hBB, 1'b1), tk(8'hCC, 1'b1)};
    for (int c = 1; c <= 13; c++) begin
      mid();
      checks++; if (go_d !== (c == 13)) begin
        failures++; $display("FAIL load_go cycle=%0d go_d=%0b exp %0b", c, go_d, (c == 13)); end
      if (c == 1)  start = 1'b0;
      if (c == 2)  arg_loaded = 3'b001;
      if (c == 7)  arg_loaded = 3'b011;
      if (c == 12) begin
        arg_loaded = 3'b111;
        arg_ptr = {tk(8'h0C, 1'b0), tk(8'h0B, 1'b1), tk(8'h0A, 1'b0)};
      end
    end
    checks++; if (arg_d !== {tk(8'h0C, 1'b1), tk(8'h0B, 1'b1), tk(8'h0A, 1'b1)}) begin
      failures++; $display("FAIL load_ptrs arg_d=%h exp %h", arg_d, {tk(8'h0C, 1'b1), tk(8'h0B, 1'b1), tk(8'h0A, 1'b1)}); end
    arg_ptr = '1; arg_loaded = '0;           // ignored once latched
    mid();                                   // RUN
    checks++; if (res_r !== 1'b1 || arg_d !== {tk(8'h0C, 1'b0), tk(8'h0B, 1'b0), tk(8'h0A, 1'b0)}) begin
      failures++; $display("FAIL load_run res_r=%0b arg_d=%h", res_r, arg_d); end
    res_d = 32'h0000_0777;
    mid();
    checks++; if (done !== 1'b1 || result_data !== 32'h777 || cycles !== 2) begin
      failures++; $display("FAIL load_done done=%0b result=%h cycles=%0d exp 1/777/2", done, result_data, cycles); end
    res_d = '0; done_ack = 1'b1;
    mid(); done_ack = 1'b0;
  endtask

  task automatic test_early_result();
    go_r = 1'b0; arg_r = '1; arg_loaded = '1; start = 1'b1; res_d = 32'h0000_00A5;
    arg_ptr = {tk(8'h01, 1'b1), tk(8'h02, 1'b1), tk(8'h03, 1'b1)};
    mid(); start = 1'b0;                     // WAIT_LOAD
    checks++; if (res_r !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL early_wait res_r=%0b done=%0b exp 0/0", res_r, done); end
    mid();                                   // T
    mid();                                   // T+1
    checks++; if (res_r !== 1'b0 || done !== 1'b0 || result_data !== 32'h777) begin
      failures++; $display("FAIL early_fire res_r=%0b done=%0b result=%h exp 0/0/777", res_r, done, result_data); end
    mid(); go_r = 1'b1;                      // T+2
    mid();                                   // T+3 : first RUN cycle
    checks++; if (res_r !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL early_run res_r=%0b done=%0b exp 1/0", res_r, done); end
    mid();
    checks++; if (done !== 1'b1 || result_data !== 32'hA5 || cycles !== 4 || res_r !== 1'b0) begin
      failures++; $display("FAIL early_done done=%0b result=%h cycles=%0d res_r=%0b exp 1/a5/4/0", done, result_data, cycles, res_r); end
    res_d = '0;
  endtask

  task automatic test_done_handshake();
    done_ack = 1'b0;
    for (int c = 0; c < 10; c++) begin
      mid();
      checks++; if (done !== 1'b1 || result_data !== 32'hA5 || cycles !== 4) begin
        failures++; $display("FAIL hs_hold cycle=%0d done=%0b result=%h cycles=%0d", c, done, result_data, cycles); end
    end
    done_ack = 1'b1; start = 1'b1;
    mid();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || result_data !== 32'hA5) begin
      failures++; $display("FAIL hs_ack done=%0b busy=%0b result=%h exp 0/0/a5", done, busy, result_data); end
    done_ack = 1'b0;
    mid();                                   // WAIT_LOAD from held start
    checks++; if (busy !== 1'b1 || go_d !== 1'b0) begin
      failures++; $display("FAIL hs_relaunch busy=%0b go_d=%0b exp 1/0", busy, go_d); end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    mid();                                   // FIRE
    checks++; if (go_d !== 1'b1) begin
      failures++; $display("FAIL rst_fire go_d=%0b exp 1", go_d); end
    mid();                                   // RUN
    checks++; if (res_r !== 1'b1) begin
      failures++; $display("FAIL rst_run res_r=%0b exp 1", res_r); end
    #1 aresetn = 1'b0;
    #1;
    checks++; if (go_d !== 1'b0 || arg_d !== '0 || res_r !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rst_async go_d=%0b arg_d=%h res_r=%0b done=%0b busy=%0b exp 0", go_d, arg_d, res_r, done, busy); end
    checks++; if (result_data !== '0 || cycles !== '0) begin
      failures++; $display("FAIL rst_async_regs result=%h cycles=%0d exp 0/0", result_data, cycles); end
    mid();
    aresetn = 1'b1; start = 1'b1; arg_loaded = '1; go_r = 1'b1; arg_r = '1;
    arg_ptr = {tk(8'h77, 1'b1), tk(8'h66, 1'b1), tk(8'h55, 1'b1)};
    mid(); start = 1'b0;                     // WAIT_LOAD
    mid();                                   // FIRE
    checks++; if (go_d !== 1'b1 || cycles !== 0 || arg_d !== {tk(8'h77, 1'b1), tk(8'h66, 1'b1), tk(8'h55, 1'b1)}) begin
      failures++; $display("FAIL rst_relaunch go_d=%0b cycles=%0d arg_d=%h", go_d, cycles, arg_d); end
    mid();                                   // RUN
    res_d = 32'h0000_0003;
    mid();
    checks++; if (done !== 1'b1 || result_data !== 32'h3 || cycles !== 2) begin
      failures++; $display("FAIL rst_done done=%0b result=%h cycles=%0d exp 1/3/2", done, result_data, cycles); end
    res_d = '0; done_ack = 1'b1;
    mid(); done_ack = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL rst_idle busy=%0b done=%0b exp 0/0", busy, done); end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NA; i++) arg_x[i] = 0;
    test_reset();
    test_basic();
    test_staggered_ready();
    test_staggered_load();
    test_early_result();
    test_done_handshake();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
